// File: rtl/pc_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_seq_pkg
// Description : Shared state encoding and default widths for pc_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_seq_pkg;

    // Sequencer states; the same encoding is used wherever the state is seen
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        HALT  = 2'd3
    } pc_state_t;

    localparam int DEF_PC_W  = 12;
    localparam int DEF_IDX_W = 5;
    localparam int DEF_CNT_W = 16;

endpackage
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Program-counter sequencer. Owns the PC, starts, advances,
//               redirects (absolute or PC-relative via the branch-target
//               table) and halts fetch; keeps a saturating run-cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int PC_W  = DEF_PC_W,
    parameter int IDX_W = DEF_IDX_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [PC_W-1:0]  Start_pc,
    input  logic             Branch_en,
    input  logic             Branch_rel,
    input  logic [IDX_W-1:0] Branch_idx,
    input  logic             Halt_req,
    input  logic             Stall,
    output logic [IDX_W-1:0] Lut_idx,
    input  logic [15:0]      Lut_target,
    output logic [PC_W-1:0]  PC,
    output logic             Fetch_valid,
    output logic             Flush,
    output logic             Done,
    output logic [CNT_W-1:0] Cycle_count
);

    pc_state_t        r_state;
    pc_state_t        w_state_next;
    logic [PC_W-1:0]  r_pc;
    logic [PC_W-1:0]  w_pc_next;
    logic [PC_W-1:0]  w_target;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_active;

    // The table is addressed straight from the instruction immediate
    assign Lut_idx = Branch_idx;

    // Branch target: the 16-bit sum wraps, and truncating it to PC_W keeps the
    // result correct modulo 2^PC_W, so negative offsets work at any PC width
    always_comb begin
        w_target = PC_W'(Branch_rel ? (16'(r_pc) + Lut_target) : Lut_target);
    end

    assign w_active = (r_state == RUN) || (r_state == FLUSH);

    // Next-state, next-PC and next-counter selection
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_cnt_next   = r_cnt;

        // Counter runs in RUN/FLUSH even while stalled, and sticks at all-ones
        if (w_active && (r_cnt != {CNT_W{1'b1}})) begin
            w_cnt_next = r_cnt + CNT_W'(1);
        end

        case (r_state)
            IDLE, HALT: begin
                if (Start) begin
                    w_state_next = RUN;
                    w_pc_next    = Start_pc;
                    w_cnt_next   = '0;
                end
            end
            RUN: begin
                if (!Stall) begin
                    if (Halt_req) begin
                        w_state_next = HALT;
                    end else if (Branch_en) begin
                        w_state_next = FLUSH;
                        w_pc_next    = w_target;
                    end else begin
                        w_pc_next    = r_pc + PC_W'(1);
                    end
                end
            end
            FLUSH: begin
                if (!Stall) begin
                    w_state_next = RUN;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // State, PC and counter registers with synchronous reset
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= IDLE;
            r_pc    <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_cnt   <= w_cnt_next;
        end
    end

    assign PC          = r_pc;
    assign Cycle_count = r_cnt;
    assign Fetch_valid = (r_state == RUN);
    assign Flush       = (r_state == FLUSH);
    assign Done        = (r_state == HALT);

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Directed self-checking bench for pc_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic [11:0] Start_pc;
    logic        Branch_en;
    logic        Branch_rel;
    logic [4:0]  Branch_idx;
    logic        Halt_req;
    logic        Stall;
    logic [4:0]  Lut_idx;
    logic [15:0] Lut_target;
    logic [11:0] PC;
    logic        Fetch_valid;
    logic        Flush;
    logic        Done;
    logic [15:0] Cycle_count;

    logic [4:0]  lut_idx_s;
    logic [11:0] pc_s;
    logic        fetch_valid_s;
    logic        flush_s;
    logic        done_s;
    logic [3:0]  cycle_count_s;

    int tests_run;
    int tests_failed;

    pc_sequencer #(.PC_W(12), .IDX_W(5), .CNT_W(16)) u_dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Start       (Start),
        .Start_pc    (Start_pc),
        .Branch_en   (Branch_en),
        .Branch_rel  (Branch_rel),
        .Branch_idx  (Branch_idx),
        .Halt_req    (Halt_req),
        .Stall       (Stall),
        .Lut_idx     (Lut_idx),
        .Lut_target  (Lut_target),
        .PC          (PC),
        .Fetch_valid (Fetch_valid),
        .Flush       (Flush),
        .Done        (Done),
        .Cycle_count (Cycle_count)
    );

    // Narrow-counter copy sharing the same stimulus, used for saturation
    pc_sequencer #(.PC_W(12), .IDX_W(5), .CNT_W(4)) u_dut_sat (
        .Clk         (Clk),
        .Reset       (Reset),
        .Start       (Start),
        .Start_pc    (Start_pc),
        .Branch_en   (Branch_en),
        .Branch_rel  (Branch_rel),
        .Branch_idx  (Branch_idx),
        .Halt_req    (Halt_req),
        .Stall       (Stall),
        .Lut_idx     (lut_idx_s),
        .Lut_target  (Lut_target),
        .PC          (pc_s),
        .Fetch_valid (fetch_valid_s),
        .Flush       (flush_s),
        .Done        (done_s),
        .Cycle_count (cycle_count_s)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_inputs();
        Start      = 1'b0;
        Branch_en  = 1'b0;
        Branch_rel = 1'b0;
        Halt_req   = 1'b0;
        Stall      = 1'b0;
    endtask

    // Issue a taken branch for one cycle, leaving the DUT in FLUSH
    task automatic branch(input logic rel, input logic [4:0] idx, input logic [15:0] tgt);
        Branch_en  = 1'b1;
        Branch_rel = rel;
        Branch_idx = idx;
        Lut_target = tgt;
        tick();
        Branch_en  = 1'b0;
        Branch_rel = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        Start_pc   = 12'h000;
        Branch_idx = 5'd0;
        Lut_target = 16'h0000;
        Reset      = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
        tests_run++; if (PC !== 12'h000) begin tests_failed++; $display("FAIL reset_pc: got %h want 000", PC); end
        tests_run++; if (Fetch_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_fetch_valid: got %b want 0", Fetch_valid); end
        tests_run++; if (Flush !== 1'b0) begin tests_failed++; $display("FAIL reset_flush: got %b want 0", Flush); end
        tests_run++; if (Done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b want 0", Done); end
        tests_run++; if (Cycle_count !== 16'd0) begin tests_failed++; $display("FAIL reset_cycle_count: got %0d want 0", Cycle_count); end
        // IDLE holds without Start
        tick();
        tests_run++; if (PC !== 12'h000 || Fetch_valid !== 1'b0) begin tests_failed++; $display("FAIL idle_hold: pc %h fv %b want 000 0", PC, Fetch_valid); end
    endtask

    task automatic test_sequential();
        Start    = 1'b1;
        Start_pc = 12'h010;
        tick();
        Start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tests_run++; if (PC !== 12'h010 + 12'(i)) begin tests_failed++; $display("FAIL seq_pc[%0d]: got %h want %h", i, PC, 12'h010 + 12'(i)); end
            tests_run++; if (Fetch_valid !== 1'b1) begin tests_failed++; $display("FAIL seq_fetch_valid[%0d]: got %b want 1", i, Fetch_valid); end
            if (i < 4) tick();
        end
        tests_run++; if (Cycle_count !== 16'd4) begin tests_failed++; $display("FAIL seq_cycle_count: got %0d want 4", Cycle_count); end
    endtask

    task automatic test_abs_branch();
        Branch_idx = 5'd2;
        Lut_target = 16'h0003;
        #1;
        tests_run++; if (Lut_idx !== 5'd2) begin tests_failed++; $display("FAIL lut_idx: got %0d want 2", Lut_idx); end
        branch(1'b0, 5'd2, 16'h0003);
        tests_run++; if (PC !== 12'h003) begin tests_failed++; $display("FAIL abs_pc: got %h want 003", PC); end
        tests_run++; if (Flush !== 1'b1) begin tests_failed++; $display("FAIL abs_flush: got %b want 1", Flush); end
        tests_run++; if (Fetch_valid !== 1'b0) begin tests_failed++; $display("FAIL abs_fetch_bubble: got %b want 0", Fetch_valid); end
        // Branch_en during FLUSH is ignored
        Branch_en  = 1'b1;
        Lut_target = 16'h0055;
        tick();
        Branch_en = 1'b0;
        tests_run++; if (Fetch_valid !== 1'b1 || Flush !== 1'b0) begin tests_failed++; $display("FAIL abs_resume: fv %b fl %b want 1 0", Fetch_valid, Flush); end
        tests_run++; if (PC !== 12'h003) begin tests_failed++; $display("FAIL abs_resume_pc: got %h want 003", PC); end
        // Upper table bits are dropped for absolute targets
        branch(1'b0, 5'd7, 16'hF123);
        tests_run++; if (PC !== 12'h123) begin tests_failed++; $display("FAIL abs_upper_bits: got %h want 123", PC); end
        tick();
    endtask

    task automatic test_rel_branch();
        branch(1'b0, 5'd1, 16'h0020);
        tick();
        branch(1'b1, 5'd3, 16'hFFFF);
        tests_run++; if (PC !== 12'h01F || Flush !== 1'b1) begin tests_failed++; $display("FAIL rel_back: pc %h fl %b want 01F 1", PC, Flush); end
        tick();
        branch(1'b1, 5'd4, 16'h0005);
        tests_run++; if (PC !== 12'h024) begin tests_failed++; $display("FAIL rel_fwd: got %h want 024", PC); end
        tick();
        branch(1'b0, 5'd0, 16'h0000);
        tick();
        branch(1'b1, 5'd3, 16'hFFFF);
        tests_run++; if (PC !== 12'hFFF) begin tests_failed++; $display("FAIL rel_wrap: got %h want FFF", PC); end
        tick();
        tests_run++; if (PC !== 12'hFFF || Fetch_valid !== 1'b1) begin tests_failed++; $display("FAIL rel_wrap_run: pc %h fv %b want FFF 1", PC, Fetch_valid); end
        tick();
        tests_run++; if (PC !== 12'h000) begin tests_failed++; $display("FAIL seq_wrap: got %h want 000", PC); end
    endtask

    task automatic test_stall();
        Halt_req = 1'b1;
        tick();
        Halt_req = 1'b0;
        Start    = 1'b1;
        Start_pc = 12'h050;
        tick();
        Start = 1'b0;
        Branch_en  = 1'b1;
        Branch_rel = 1'b0;
        Lut_target = 16'h0040;
        Stall      = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            tests_run++; if (PC !== 12'h050 || Fetch_valid !== 1'b1) begin tests_failed++; $display("FAIL stall_hold[%0d]: pc %h fv %b want 050 1", i, PC, Fetch_valid); end
            tests_run++; if (Cycle_count !== 16'(i)) begin tests_failed++; $display("FAIL stall_count[%0d]: got %0d want %0d", i, Cycle_count, i); end
        end
        Stall = 1'b0;
        tick();
        Branch_en = 1'b0;
        tests_run++; if (PC !== 12'h040 || Flush !== 1'b1) begin tests_failed++; $display("FAIL stall_redirect: pc %h fl %b want 040 1", PC, Flush); end
        Stall = 1'b1;
        tick();
        tests_run++; if (Flush !== 1'b1 || Cycle_count !== 16'd5) begin tests_failed++; $display("FAIL stall_flush: fl %b cnt %0d want 1 5", Flush, Cycle_count); end
        Stall = 1'b0;
        tick();
        tests_run++; if (Fetch_valid !== 1'b1 || PC !== 12'h040) begin tests_failed++; $display("FAIL stall_flush_exit: fv %b pc %h want 1 040", Fetch_valid, PC); end
        // Start ignored while running
        Start    = 1'b1;
        Start_pc = 12'h007;
        tick();
        Start = 1'b0;
        tests_run++; if (PC !== 12'h041 || Cycle_count !== 16'd7) begin tests_failed++; $display("FAIL start_ignored: pc %h cnt %0d want 041 7", PC, Cycle_count); end
    endtask

    task automatic test_halt();
        Halt_req   = 1'b1;
        Branch_en  = 1'b1;
        Lut_target = 16'h00AA;
        tick();
        Halt_req  = 1'b0;
        Branch_en = 1'b0;
        tests_run++; if (Done !== 1'b1 || PC !== 12'h041 || Fetch_valid !== 1'b0) begin tests_failed++; $display("FAIL halt: done %b pc %h fv %b want 1 041 0", Done, PC, Fetch_valid); end
        tick();
        tick();
        tests_run++; if (Done !== 1'b1 || Cycle_count !== 16'd8) begin tests_failed++; $display("FAIL halt_sticky: done %b cnt %0d want 1 8", Done, Cycle_count); end
        Start    = 1'b1;
        Start_pc = 12'h100;
        tick();
        Start = 1'b0;
        tests_run++; if (PC !== 12'h100 || Done !== 1'b0 || Fetch_valid !== 1'b1) begin tests_failed++; $display("FAIL restart: pc %h done %b fv %b want 100 0 1", PC, Done, Fetch_valid); end
        tests_run++; if (Cycle_count !== 16'd0) begin tests_failed++; $display("FAIL restart_count: got %0d want 0", Cycle_count); end
    endtask

    task automatic test_reset_in_flush();
        branch(1'b0, 5'd9, 16'h0077);
        tests_run++; if (Flush !== 1'b1) begin tests_failed++; $display("FAIL pre_reset_flush: got %b want 1", Flush); end
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        tests_run++; if (PC !== 12'h000 || Flush !== 1'b0 || Done !== 1'b0 || Fetch_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_flush: pc %h fl %b done %b fv %b want 000 0 0 0", PC, Flush, Done, Fetch_valid); end
        tests_run++; if (Cycle_count !== 16'd0) begin tests_failed++; $display("FAIL reset_flush_count: got %0d want 0", Cycle_count); end
    endtask

    task automatic test_saturation();
        Start    = 1'b1;
        Start_pc = 12'h200;
        tick();
        Start = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 14) begin
                tests_run++; if (cycle_count_s !== 4'd14) begin tests_failed++; $display("FAIL sat_pre: got %0d want 14", cycle_count_s); end
            end
        end
        tests_run++; if (cycle_count_s !== 4'hF) begin tests_failed++; $display("FAIL sat_hold: got %h want F", cycle_count_s); end
        tests_run++; if (Cycle_count !== 16'd20) begin tests_failed++; $display("FAIL wide_count: got %0d want 20", Cycle_count); end
        tests_run++; if (pc_s !== 12'h214) begin tests_failed++; $display("FAIL sat_pc: got %h want 214", pc_s); end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_sequential();
        test_abs_branch();
        test_rel_branch();
        test_stall();
        test_halt();
        test_reset_in_flush();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the basic processor. It owns the PC and starts, advances, redirects and halts instruction fetch. It drives the 5-bit index into the external branch-target lookup table and forms the next PC from the returned 16-bit target, as either an absolute address or a PC-relative offset. It sits between the decoder/branch-condition logic and instruction memory, and also keeps a saturating run-cycle counter for performance reporting.

## Interface
Parameters:
- PC_W, 12, PC / instruction-memory address width (must be 2..16)
- IDX_W, 5, branch-target table index width
- CNT_W, 16, cycle counter width

Ports:
- Clk  in  1  single clock; all state changes on rising edge
- Reset  in  1  synchronous, active-high; takes effect on the Clk edge where it is sampled high
- Start  in  1  one-cycle pulse: begin execution at Start_pc
- Start_pc  in  PC_W  first fetch address
- Branch_en  in  1  taken branch/jump in the current instruction (condition already resolved)
- Branch_rel  in  1  1 = Target is signed offset added to PC, 0 = Target is absolute address
- Branch_idx  in  IDX_W  table index from instruction immediate
- Halt_req  in  1  current instruction is HALT
- Stall  in  1  freeze PC and state this cycle
- Lut_idx  out  IDX_W  to lookup table (combinational copy of Branch_idx)
- Lut_target  in  16  target from lookup table (combinational)
- PC  out  PC_W  fetch address, registered
- Fetch_valid  out  1  PC holds an instruction to execute this cycle
- Flush  out  1  taken-branch bubble; downstream discards its instruction
- Done  out  1  program halted; sticky
- Cycle_count  out  CNT_W  cycles spent in RUN/FLUSH, saturating

## Operation
- States (shared enum): IDLE, RUN, FLUSH, HALT.
- IDLE: PC holds, Fetch_valid=0. Start=1 → PC<=Start_pc, Cycle_count<=0, Done<=0, go to RUN.
- RUN, Stall=0, priority Halt_req > Branch_en > sequential:
  - Halt_req: PC holds, go to HALT.
  - Branch_en: PC<=next_target, go to FLUSH.
  - else: PC<=PC+1.
- RUN or FLUSH, Stall=1: PC, state and inputs' effect all frozen. The decoder holds Branch_en/Halt_req until Stall drops. Cycle_count still increments.
- FLUSH: lasts one cycle, then returns to RUN. PC holds. Branch_en/Halt_req ignored.
- HALT: Done=1, PC holds. Start=1 restarts exactly as from IDLE.
- Start is ignored in RUN and FLUSH.
- next_target:
  - Branch_rel=0: Lut_target[PC_W-1:0] (upper bits ignored).
  - Branch_rel=1: PC + Lut_target[PC_W-1:0], modulo 2^PC_W. Two's-complement wrap, so negative offsets work.
- PC+1 at all-ones wraps to 0.
- Cycle_count increments every cycle in RUN or FLUSH and saturates at all-ones.

## Timing
- Reset values: state=IDLE, PC=0, Fetch_valid=0, Flush=0, Done=0, Cycle_count=0.
- Reset has priority over every input, including mid-RUN and mid-FLUSH.
- Outputs are decoded from registered state:
  - Fetch_valid = (state==RUN)
  - Flush = (state==FLUSH)
  - Done = (state==HALT)
- Lut_idx is combinational from Branch_idx, zero latency. Lut_target is used in the same cycle.
- Start sampled at edge t → at t+1: RUN, PC=Start_pc, Fetch_valid=1.
- Taken branch sampled at t → at t+1: PC=target, Flush=1, Fetch_valid=0. At t+2: Fetch_valid=1 at target. Penalty is one cycle.
- Halt_req sampled at t → Done=1 at t+1, where it stays until Reset or Start.

## Structure
- Package pc_seq_pkg contains:
  - state enum (IDLE, RUN, FLUSH, HALT)
  - default PC_W, IDX_W, CNT_W localparams
- Single module with no sub-module. The lookup table is instantiated beside it at processor top level.
- Next-PC adder/mux is an always_comb block. State, PC and counter live in one always_ff block with synchronous Reset.

## Test plan
- Reset, then Start with Start_pc=0x010 and no branches for 5 cycles → PC goes 0x010..0x014, Fetch_valid=1, Cycle_count=4 on the 5th cycle.
- Absolute branch: Branch_en=1, Branch_rel=0, Branch_idx=2, table returns 0x0003 → Lut_idx=2. Next cycle PC=0x003 with Flush=1. Cycle after that, Fetch_valid=1.
- Relative backward branch at PC=0x020, table returns 0xFFFF → PC=0x01F. Also, at PC=0x000 with offset 0xFFFF → PC=0xFFF (wrap). Sequential step from 0xFFF → 0x000.
- Stall held 3 cycles while Branch_en=1 → PC unchanged for those 3 cycles and Cycle_count +3. Redirect occurs on the first cycle with Stall=0.
- Halt_req and Branch_en both high → HALT with PC unchanged and Done=1. A later Start with Start_pc=0x100 → RUN at PC=0x100, Done=0, Cycle_count=0.
- Reset asserted during FLUSH → next cycle IDLE, PC=0, Flush=0, Done=0, Cycle_count=0. Run a saturation check with CNT_W=4: after 20 RUN cycles, Cycle_count=0xF.
